tt_um_toivoh_pio_ram_emu_example: RTL and testbench

Tiny Tapeout user project that demonstrates the PIO RAM emulator link. It runs an endless loop of 16-bit read or write transactions to an external RAM, sent as a 2-bit-wide serial link: tx on uio_out[5:4], rx on uio_in[7:6]. The last word read is shown on uo_out. All link pins are registered in both directions.

---
 rtl/tt_um_toivoh_pio_ram_emu_example.sv | 133 +++++++++++++
 tb/tb_tt_um_toivoh_pio_ram_emu_example.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_toivoh_pio_ram_emu_example.sv
// Demo client for the PIO RAM emulator link.
// Runs an endless loop of 16-bit reads or writes over a 2-bit serial link
// and shows the most recently read word on uo_out.
module tt_um_toivoh_pio_ram_emu_example #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // One counter serves SEND (up to 16), RECV (up to 7) and the WAIT timeout
    localparam int CW = ($clog2(TIMEOUT_CYCLES) > 5) ? $clog2(TIMEOUT_CYCLES) : 5;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RECV = 2'd3;

    localparam logic [CW-1:0] READ_LAST  = CW'(8);
    localparam logic [CW-1:0] WRITE_LAST = CW'(16);
    localparam logic [CW-1:0] RECV_LAST  = CW'(7);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state;
    logic [1:0]    tx_reg;
    logic [1:0]    rx_reg;
    logic [15:0]   addr;
    logic [15:0]   data;
    logic [13:0]   shift_reg;
    logic [CW-1:0] cnt;
    logic          write_mode;

    logic [31:0]   msg_payload;
    logic [4:0]    pair_idx;
    logic [1:0]    next_pair;
    logic [CW-1:0] send_last;

    logic          unused_inputs;
    assign unused_inputs = &{1'b0, ena, ui_in[7:2], uio_in[5:0]};

    // Pick the pair that goes on the wire in the next SEND cycle: address first, then ~addr as write data
    always_comb begin
        msg_payload = {~addr, addr};
        pair_idx    = {cnt[3:0], 1'b0};
        next_pair   = msg_payload[pair_idx +: 2];
        send_last   = write_mode ? WRITE_LAST : READ_LAST;
    end

    // Input pin register so the FSM only ever sees a clean registered rx pair
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_reg <= 2'b00;
        end else begin
            rx_reg <= uio_in[7:6];
        end
    end

    // Transaction sequencer: IDLE -> SEND -> (WAIT -> RECV for reads) -> IDLE, with registered tx pins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_reg     <= 2'b00;
            addr       <= 16'h0000;
            data       <= 16'h0000;
            shift_reg  <= 14'h0000;
            cnt        <= '0;
            write_mode <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    write_mode <= ui_in[0];
                    tx_reg     <= {ui_in[0], 1'b1};
                    cnt        <= '0;
                    state      <= SEND;
                end
                SEND: begin
                    if (cnt == send_last) begin
                        tx_reg <= 2'b00;
                        cnt    <= '0;
                        if (write_mode) begin
                            addr  <= addr + 16'd1;
                            state <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end else begin
                        tx_reg <= next_pair;
                        cnt    <= cnt + CW'(1);
                    end
                end
                WAIT: begin
                    if (rx_reg[0]) begin
                        cnt   <= '0;
                        state <= RECV;
                    end else if (cnt == WAIT_LAST) begin
                        data  <= 16'hFFFF;
                        addr  <= addr + 16'd1;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RECV: begin
                    shift_reg <= {rx_reg, shift_reg[13:2]};
                    if (cnt == RECV_LAST) begin
                        data  <= {rx_reg, shift_reg};
                        addr  <= addr + 16'd1;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_reg <= 2'b00;
                end
            endcase
        end
    end

    assign uo_out  = ui_in[1] ? data[15:8] : data[7:0];
    assign uio_out = {2'b00, tx_reg, 4'b0000};
    assign uio_oe  = 8'b0011_0000;

endmodule

// File: tb/tb_tt_um_toivoh_pio_ram_emu_example.sv
// Bench for the PIO RAM emulator demo: a monitor decodes tx messages and
// checks them against a queue of expected messages, while a RAM model
// answers reads with a 22-cycle reply latency.
module tb_tt_um_toivoh_pio_ram_emu_example;

    typedef struct {
        bit          is_write;
        logic [15:0] addr;
        logic [15:0] wdata;
    } msg_t;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    msg_t        exp_q[$];
    bit          plan_q[$];
    int          start_times[$];
    logic [15:0] mem [logic [15:0]];

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          reply_at = -1000;
    logic [15:0] reply_word = 16'h0000;

    bit          dec_active = 1'b0;
    bit          dec_type;
    int          dec_cnt;
    int          dec_start;
    logic [15:0] dec_addr;
    logic [15:0] dec_wdata;

    tt_um_toivoh_pio_ram_emu_example #(.TIMEOUT_CYCLES(255)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to timestamp message starts and schedule replies
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        n_checks++;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion earlier");
        finishRun();
    end

    function automatic logic [15:0] defaultWord(input logic [15:0] a);
        return {a[7:0] ^ 8'h3C, a[7:0]};
    endfunction

    function automatic logic [15:0] expWord(input int a);
        logic [15:0] a16;
        a16 = 16'(a);
        if (a == 0) return 16'hA55A;
        if (a == 1) return 16'h00C3;
        if (a == 2) return 16'hFFFD;
        return defaultWord(a16);
    endfunction

    task automatic finishRun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input logic rst_val, input logic [7:0] ui_val);
        rst_n = rst_val;
        ui_in = ui_val;
    endtask

    task automatic waitStart(input int target, input int budget);
        int waited;
        waited = 0;
        while (start_times.size() < target && waited < budget) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (start_times.size() < target) begin
            n_checks++;
            $display("[TB] FAIL start %0d: no message start within %0d cycles, expected one", target, budget);
            finishRun();
        end
    endtask

    task automatic pushRead(input int a, input bit reply);
        msg_t m;
        m.is_write = 1'b0;
        m.addr     = 16'(a);
        m.wdata    = 16'h0000;
        exp_q.push_back(m);
        plan_q.push_back(reply);
    endtask

    task automatic pushWrite(input int a, input logic [15:0] wd);
        msg_t m;
        m.is_write = 1'b1;
        m.addr     = 16'(a);
        m.wdata    = wd;
        exp_q.push_back(m);
    endtask

    // Monitor: decode tx messages and compare each finished one with the scoreboard
    initial begin
        forever begin
            logic [1:0] tx;
            msg_t       e;
            @(negedge clk);
            tx = uio_out[5:4];
            if (!rst_n) begin
                dec_active = 1'b0;
            end else if (!dec_active) begin
                if (tx[0]) begin
                    dec_active = 1'b1;
                    dec_type   = tx[1];
                    dec_cnt    = 0;
                    dec_start  = cyc;
                    dec_addr   = 16'h0000;
                    dec_wdata  = 16'h0000;
                    start_times.push_back(cyc);
                end
            end else begin
                if (dec_cnt < 8) dec_addr[2*dec_cnt +: 2] = tx;
                else dec_wdata[2*(dec_cnt-8) +: 2] = tx;
                dec_cnt++;
                if (dec_cnt == (dec_type ? 16 : 8)) begin
                    dec_active = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("[TB] FAIL unexpected message: type %0d addr %0h, expected none", dec_type, dec_addr);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("msg type", 32'(dec_type), 32'(e.is_write));
                        checkOutput("msg addr", 32'(dec_addr), 32'(e.addr));
                        if (e.is_write) checkOutput("msg wdata", 32'(dec_wdata), 32'(e.wdata));
                    end
                    if (dec_type) begin
                        mem[dec_addr] = dec_wdata;
                    end else if (plan_q.size() > 0) begin
                        if (plan_q.pop_front()) begin
                            reply_at   = dec_start + 22;
                            reply_word = mem.exists(dec_addr) ? mem[dec_addr] : defaultWord(dec_addr);
                        end
                    end
                end
            end
        end
    end

    // RAM model pin driver: start pair 01 then the data pairs LSB first
    initial begin
        uio_in = 8'b0010_1010;
        forever begin
            int rel;
            @(negedge clk);
            rel = cyc - reply_at;
            if (rel == 0) uio_in[7:6] = 2'b01;
            else if (rel >= 1 && rel <= 8) uio_in[7:6] = reply_word[2*(rel-1) +: 2];
            else uio_in[7:6] = 2'b00;
        end
    end

    // Directed stimulus and output-pin checks
    initial begin
        int r;
        logic [15:0] w;
        ena = 1'b1;
        applyStimulus(1'b0, 8'h00);
        mem[16'h0000] = 16'hA55A;
        mem[16'h0001] = 16'h00C3;
        pushRead(0, 1'b1);
        pushRead(1, 1'b1);
        pushWrite(2, 16'hFFFD);
        pushRead(3, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset uo_out", 32'(uo_out), 32'h00);
        checkOutput("reset uio_out", 32'(uio_out), 32'h00);
        checkOutput("uio_oe", 32'(uio_oe), 32'h30);
        r = cyc;
        applyStimulus(1'b1, 8'h00);

        waitStart(1, 20);
        checkOutput("first start delay", 32'(start_times[0] - r), 32'd1);
        checkOutput("uo_out before reply", 32'(uo_out), 32'h00);

        waitStart(2, 300);
        checkOutput("read reply spacing", 32'(start_times[1] - start_times[0]), 32'd33);
        checkOutput("reply low byte", 32'(uo_out), 32'h5A);
        applyStimulus(1'b1, 8'h02);
        #1;
        checkOutput("reply high byte", 32'(uo_out), 32'hA5);
        applyStimulus(1'b1, 8'h01);

        waitStart(3, 300);
        checkOutput("read1 spacing", 32'(start_times[2] - start_times[1]), 32'd33);
        checkOutput("read1 low byte", 32'(uo_out), 32'hC3);
        applyStimulus(1'b1, 8'h00);

        waitStart(4, 300);
        checkOutput("write spacing", 32'(start_times[3] - start_times[2]), 32'd18);
        checkOutput("uo_out after write", 32'(uo_out), 32'hC3);
        applyStimulus(1'b1, 8'h02);
        #1;
        checkOutput("uo_out high after write", 32'(uo_out), 32'h00);
        applyStimulus(1'b1, 8'h00);

        waitStart(5, 400);
        checkOutput("timeout spacing", 32'(start_times[4] - start_times[3]), 32'd265);
        checkOutput("timeout low byte", 32'(uo_out), 32'hFF);
        applyStimulus(1'b1, 8'h02);
        #1;
        checkOutput("timeout high byte", 32'(uo_out), 32'hFF);
        applyStimulus(1'b1, 8'h00);

        @(negedge clk);
        #1;
        applyStimulus(1'b0, 8'h00);
        @(negedge clk);
        #1;
        checkOutput("tx after reset edge", 32'(uio_out), 32'h00);
        checkOutput("uo_out after reset", 32'(uo_out), 32'h00);
        for (int k = 0; k < 20; k++) pushRead(k, 1'b1);
        @(negedge clk);
        #1;
        r = cyc;
        applyStimulus(1'b1, 8'h00);

        waitStart(6, 20);
        checkOutput("restart start delay", 32'(start_times[5] - r), 32'd1);
        checkOutput("uo_out at restart", 32'(uo_out), 32'h00);

        for (int k = 1; k <= 20; k++) begin
            waitStart(6 + k, 300);
            checkOutput("emu spacing", 32'(start_times[5+k] - start_times[4+k]), 32'd33);
            w = expWord(k - 1);
            checkOutput("emu low byte", 32'(uo_out), 32'(w[7:0]));
            applyStimulus(1'b1, 8'h02);
            #1;
            checkOutput("emu high byte", 32'(uo_out), 32'(w[15:8]));
            applyStimulus(1'b1, 8'h00);
        end
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] done at cycle %0d", cyc);
        finishRun();
    end

endmodule
